// File: rtl/phase_pkg.sv
// Shared definitions for the CPU phase-rotation monitor: one-hot phase codes,
// error/state enums and the rotation helpers.
package phase_pkg;

  localparam int unsigned PH_W = 4;

  typedef logic [PH_W-1:0] phase_t;

  // Bus order is {decode, exec, rdmem, fetch}
  localparam phase_t PH_RDMEM  = 4'b0010;
  localparam phase_t PH_FETCH  = 4'b0001;
  localparam phase_t PH_DECODE = 4'b1000;
  localparam phase_t PH_EXEC   = 4'b0100;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_NOT_ONEHOT = 2'd1,
    ERR_ORDER      = 2'd2,
    ERR_BAD_START  = 2'd3
  } err_code_t;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_t;

  // Rotation rdmem -> fetch -> decode -> exec -> rdmem
  function automatic phase_t next_phase(input phase_t p);
    phase_t n;
    case (p)
      PH_RDMEM:  n = PH_FETCH;
      PH_FETCH:  n = PH_DECODE;
      PH_DECODE: n = PH_EXEC;
      PH_EXEC:   n = PH_RDMEM;
      default:   n = PH_RDMEM;
    endcase
    return n;
  endfunction

  function automatic logic is_onehot(input phase_t p);
    return (p != '0) && ((p & (p - PH_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/phase_checker.sv
// Monitors the one-hot phase strobes, counts completed instruction cycles and
// captures the first protocol violation until clear or reset.
module phase_checker
  import phase_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 phase_decode,
  input  logic                 phase_exec,
  input  logic                 phase_rdmem,
  input  logic                 phase_fetch,
  input  logic                 clear,
  output logic                 locked,
  output logic [CNT_WIDTH-1:0] inst_count,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [PH_W-1:0]      err_phases,
  output logic [PH_W-1:0]      err_expected
);

  state_t state;
  phase_t expected;
  phase_t p;

  assign p = {phase_decode, phase_exec, phase_rdmem, phase_fetch};

  // Single-process FSM; every output is a register updated alongside the state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= WAIT;
      expected     <= PH_RDMEM;
      locked       <= 1'b0;
      inst_count   <= '0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
      err_phases   <= '0;
      err_expected <= '0;
    end else if (clear) begin
      state        <= WAIT;
      expected     <= PH_RDMEM;
      locked       <= 1'b0;
      inst_count   <= '0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
      err_phases   <= '0;
      err_expected <= '0;
    end else begin
      case (state)
        WAIT: begin
          if (p == PH_RDMEM) begin
            state    <= TRACK;
            locked   <= 1'b1;
            expected <= PH_FETCH;
          end else if (p != '0) begin
            state        <= ERROR;
            locked       <= 1'b0;
            err          <= 1'b1;
            err_code     <= is_onehot(p) ? ERR_BAD_START : ERR_NOT_ONEHOT;
            err_phases   <= p;
            err_expected <= expected;
          end
        end
        TRACK: begin
          if (p == expected) begin
            expected <= next_phase(p);
            if (p == PH_EXEC) begin
              inst_count <= inst_count + CNT_WIDTH'(1);
            end
          end else begin
            state        <= ERROR;
            locked       <= 1'b0;
            err          <= 1'b1;
            err_code     <= is_onehot(p) ? ERR_ORDER : ERR_NOT_ONEHOT;
            err_phases   <= p;
            err_expected <= expected;
          end
        end
        ERROR: begin
          // First error wins: capture and count hold until clear/reset
          state <= ERROR;
        end
        default: begin
          state    <= WAIT;
          expected <= PH_RDMEM;
          locked   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/phase_checker.md
Name: phase_checker

Overview:
- Consumer-side monitor for the four one-hot phase strobes issued by the CPU phase generator (`signalizer`).
- Phase bus order is {decode, exec, rdmem, fetch}.
- Locks onto the rotation rdmem -> fetch -> decode -> exec -> rdmem and counts completed instruction cycles.
- Flags the first protocol violation (non-one-hot, wrong order, bad start) with a sticky error and a capture of the offending sample; used in simulation and as an on-chip debug status source.

Parameters:
- CNT_WIDTH, 16, width of completed-cycle counter inst_count.

Ports:
- clk  input  1  system clock, all sampling on posedge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- phase_decode  input  1  decode phase strobe.
- phase_exec  input  1  exec phase strobe.
- phase_rdmem  input  1  rdmem phase strobe.
- phase_fetch  input  1  fetch phase strobe.
- clear  input  1  synchronous clear: counter, error and lock state.
- locked  output  1  high while in TRACK state.
- inst_count  output  CNT_WIDTH  number of exec phases accepted in TRACK.
- err  output  1  sticky protocol-error flag.
- err_code  output  2  0 none, 1 NOT_ONEHOT, 2 ORDER, 3 BAD_START.
- err_phases  output  4  sampled {decode,exec,rdmem,fetch} at the error.
- err_expected  output  4  phase vector expected at the error.

Behaviour:
- Reset (rst=0, async): state=WAIT, locked=0, inst_count=0, err=0, err_code=0, err_phases=0, err_expected=0, expected=4'b0010.
- p = {phase_decode, phase_exec, phase_rdmem, phase_fetch}, sampled every posedge. All outputs are registered, so the response appears one cycle after the sample.
- State WAIT:
  - p==0000: stay in WAIT (generator still in reset).
  - p==0010: go to TRACK, expected<=0001.
  - Any other p: go to ERROR. Code is 3 if p is one-hot, else 1.
- State TRACK:
  - p==expected: stay in TRACK and advance expected along 0010->0001->1000->0100->0010.
  - When the accepted p==0100 (exec): inst_count<=inst_count+1, wrapping modulo 2^CNT_WIDTH with no saturation.
  - p not one-hot (including 0000): go to ERROR, code 1.
  - p one-hot but != expected: go to ERROR, code 2.
- Entering ERROR, all in the same cycle:
  - err<=1.
  - err_phases<=p.
  - err_expected<=expected (0010 when leaving WAIT).
- ERROR is terminal until clear or reset.
  - Error registers and inst_count hold.
  - Later violations do not overwrite the capture (first error wins).
- clear=1 at a posedge: state=WAIT plus all reset values, regardless of state. clear has priority over any error or count event in the same cycle.
- Async rst mid-TRACK or mid-ERROR: immediate return to reset values. No dependence on rst release alignment beyond the normal clock.
- locked=1 only in TRACK. It drops in the cycle err rises.

Decomposition:
- Shared package phase_pkg holds:
  - One-hot constants PH_RDMEM=4'b0010, PH_FETCH=4'b0001, PH_DECODE=4'b1000, PH_EXEC=4'b0100.
  - Enum err_code_t {ERR_NONE, ERR_NOT_ONEHOT, ERR_ORDER, ERR_BAD_START}.
  - State enum {WAIT, TRACK, ERROR}.
  - Pure function next_phase(4-bit) implementing the rotation.
  - Function is_onehot(4-bit).
- No sub-module needed; single module using the package.

Test Plan:
- Release rst, drive 0000 for 2 cycles, then correct rotation from 0010 for 8 phases -> locked=1 from cycle after first 0010, inst_count=2, err=0.
- Normal lock, then drive 0001 twice in a row -> err=1, err_code=2, err_phases=0001, err_expected=1000, locked=0, inst_count frozen.
- Drive 0011 during TRACK -> err_code=1, err_phases=0011. A subsequent 1100 leaves the capture unchanged.
- After reset drive 1000 first -> err_code=3, err_phases=1000, err_expected=0010.
- Error state plus clear=1 for one cycle, then correct rotation -> err=0, inst_count=0 after clear, relock and count resumes. clear coincident with a violation -> no error.
- CNT_WIDTH=2: 5 full rotations -> inst_count sequence 1,2,3,0,1.
- Pull rst low mid-rotation -> outputs are reset values before the next posedge.
